// File: rtl/gardner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gardner_pkg
// Purpose  : Shared state encoding, default loop gains and the |x| width rule
//            for the Gardner loop sequencing controller.
// Revision : 1.0 - initial release
// ============================================================================
package gardner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RESET_DP = 2'd1,
        ST_ACQUIRE  = 2'd2,
        ST_TRACK    = 2'd3
    } gardner_state_e;

    localparam int c_shift_acq_def = 3;
    localparam int c_shift_trk_def = 6;

    // Saturating |x| of a WIDTH-bit signed word always fits in WIDTH-1 bits.
    function automatic int sat_abs_width(input int width);
        return width - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gardner_lock_detect.sv
`default_nettype none
// ============================================================================
// Module   : gardner_lock_detect
// Purpose  : Windowed mean-|error| accumulator with lock/unlock threshold
//            compare and a saturating consecutive-bad-window counter.
// Revision : 1.0 - initial release
// ============================================================================
module gardner_lock_detect
    import gardner_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int WIN_LOG2     = 5,
    parameter int LOSS_WINDOWS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    active,
    input  logic                    clear,
    input  logic                    sym_valid,
    input  logic signed [WIDTH-1:0] error_n,
    input  logic [WIDTH-2:0]        lock_thresh,
    input  logic [WIDTH-2:0]        unlock_thresh,
    output logic                    win_good,
    output logic                    win_bad_n
);

    localparam int c_abs_w = sat_abs_width(WIDTH);
    localparam int c_acc_w = WIDTH + WIN_LOG2;
    localparam int c_bad_w = $clog2(LOSS_WINDOWS + 1);
    localparam logic [c_bad_w-1:0] c_loss = c_bad_w'(LOSS_WINDOWS);

    logic [WIDTH-1:0]    w_neg;
    logic [c_abs_w-1:0]  w_abs;
    logic [c_acc_w-1:0]  r_acc;
    logic [c_acc_w-1:0]  w_sum;
    logic [c_acc_w-1:0]  w_lock_lim;
    logic [c_acc_w-1:0]  w_unlock_lim;
    logic [WIN_LOG2-1:0] r_win_cnt;
    logic [c_bad_w-1:0]  r_bad;
    logic [c_bad_w-1:0]  w_bad_nxt;
    logic                w_close;

    assign w_neg = -error_n;

    // Negating the most negative value wraps back to negative; clamp it.
    always_comb begin
        w_abs = error_n[c_abs_w-1:0];
        if (error_n[WIDTH-1]) begin
            w_abs = w_neg[WIDTH-1] ? {c_abs_w{1'b1}} : w_neg[c_abs_w-1:0];
        end
    end

    assign w_sum        = r_acc + c_acc_w'(w_abs);
    assign w_lock_lim   = {1'b0, lock_thresh,   {WIN_LOG2{1'b0}}};
    assign w_unlock_lim = {1'b0, unlock_thresh, {WIN_LOG2{1'b0}}};
    assign w_close      = active & sym_valid & (r_win_cnt == {WIN_LOG2{1'b1}});

    always_comb begin
        win_good  = 1'b0;
        win_bad_n = 1'b0;
        w_bad_nxt = r_bad;
        if (w_close) begin
            if (w_sum < w_lock_lim) begin
                win_good  = 1'b1;
                w_bad_nxt = '0;
            end else if (w_sum > w_unlock_lim) begin
                w_bad_nxt = (r_bad == c_loss) ? c_loss : r_bad + c_bad_w'(1);
                win_bad_n = (w_bad_nxt == c_loss);
            end else begin
                w_bad_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_win_cnt <= '0;
            r_bad     <= '0;
        end else if (clear) begin
            r_acc     <= '0;
            r_win_cnt <= '0;
            r_bad     <= '0;
        end else if (active && sym_valid) begin
            r_acc     <= w_close ? '0 : w_sum;
            r_win_cnt <= r_win_cnt + WIN_LOG2'(1);
            r_bad     <= w_bad_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gardner_loop_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gardner_loop_ctrl
// Purpose  : Gardner loop sequencer: datapath reset, wide-gain acquire,
//            narrow-gain track with hysteretic lock and loss fallback.
//            Define GARDNER_CTRL_STATS_EN to build the lock-loss counter.
// Revision : 1.0 - initial release
// ============================================================================
module gardner_loop_ctrl
    import gardner_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int SHIFT_ACQ    = c_shift_acq_def,
    parameter int SHIFT_TRK    = c_shift_trk_def,
    parameter int RST_CYCLES   = 4,
    parameter int ACQ_SYMS     = 256,
    parameter int WIN_LOG2     = 5,
    parameter int LOSS_WINDOWS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    sym_valid,
    input  logic signed [WIDTH-1:0] error_n,
    input  logic [WIDTH-2:0]        lock_thresh,
    input  logic [WIDTH-2:0]        unlock_thresh,
    output logic                    dp_rst,
    output logic [3:0]              gardner_shift,
    output logic                    locked,
    output logic [1:0]              state_o,
    output logic [7:0]              loss_cnt
);

    localparam int c_rst_w = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [c_rst_w-1:0] c_rst_last = c_rst_w'(RST_CYCLES - 1);
    localparam logic [15:0]        c_acq_last = 16'(ACQ_SYMS - 1);

    gardner_state_e     r_state;
    gardner_state_e     w_state_nxt;
    logic [c_rst_w-1:0] r_rst_cnt;
    logic [15:0]        r_sym_cnt;
    logic               r_dp_rst;
    logic [3:0]         r_shift;
    logic               r_locked;
    logic               w_rst_done;
    logic               w_acq_done;
    logic               w_win_good;
    logic               w_win_bad_n;
    logic               w_loss;
    logic               w_ld_clear;

    assign w_rst_done = (r_state == ST_RESET_DP) && (r_rst_cnt == c_rst_last);
    assign w_acq_done = (r_state == ST_ACQUIRE) && sym_valid && (r_sym_cnt == c_acq_last);
    assign w_loss     = enable && r_locked && w_win_bad_n;
    assign w_ld_clear = (r_state != ST_TRACK) || !enable || w_loss;

    gardner_lock_detect #(
        .WIDTH        (WIDTH),
        .WIN_LOG2     (WIN_LOG2),
        .LOSS_WINDOWS (LOSS_WINDOWS)
    ) u_lock_detect (
        .clk           (clk),
        .rst           (rst),
        .active        (r_state == ST_TRACK),
        .clear         (w_ld_clear),
        .sym_valid     (sym_valid),
        .error_n       (error_n),
        .lock_thresh   (lock_thresh),
        .unlock_thresh (unlock_thresh),
        .win_good      (w_win_good),
        .win_bad_n     (w_win_bad_n)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (enable)     w_state_nxt = ST_RESET_DP;
            ST_RESET_DP: if (w_rst_done) w_state_nxt = ST_ACQUIRE;
            ST_ACQUIRE:  if (w_acq_done) w_state_nxt = ST_TRACK;
            ST_TRACK:    if (w_loss)     w_state_nxt = ST_ACQUIRE;
            default:                     w_state_nxt = ST_IDLE;
        endcase
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs are registered from the next-state decode so they move with state_o.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_cnt <= '0;
            r_sym_cnt <= '0;
            r_dp_rst  <= 1'b1;
            r_shift   <= 4'(SHIFT_ACQ);
            r_locked  <= 1'b0;
        end else begin
            r_dp_rst <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_RESET_DP);
            r_shift  <= (w_state_nxt == ST_TRACK) ? 4'(SHIFT_TRK) : 4'(SHIFT_ACQ);

            if (enable && (r_state == ST_RESET_DP) && !w_rst_done) begin
                r_rst_cnt <= r_rst_cnt + c_rst_w'(1);
            end else begin
                r_rst_cnt <= '0;
            end

            if (enable && (r_state == ST_ACQUIRE) && !w_acq_done) begin
                r_sym_cnt <= r_sym_cnt + (sym_valid ? 16'd1 : 16'd0);
            end else begin
                r_sym_cnt <= '0;
            end

            if (!enable || w_loss) begin
                r_locked <= 1'b0;
            end else if ((r_state == ST_TRACK) && w_win_good) begin
                r_locked <= 1'b1;
            end
        end
    end

`ifdef GARDNER_CTRL_STATS_EN
    logic [7:0] r_loss_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_loss_cnt <= 8'd0;
        end else if (w_loss && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign loss_cnt = r_loss_cnt;
`else
    assign loss_cnt = 8'd0;
`endif

    assign dp_rst        = r_dp_rst;
    assign gardner_shift = r_shift;
    assign locked        = r_locked;
    assign state_o       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_gardner_loop_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gardner_loop_ctrl
// Purpose  : Directed self-checking bench for gardner_loop_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gardner_loop_ctrl;

`ifdef GARDNER_CTRL_STATS_EN
    localparam int c_exp_loss = 1;
`else
    localparam int c_exp_loss = 0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic               sym_valid;
    logic signed [15:0] error_n;
    logic [14:0]        lock_thresh;
    logic [14:0]        unlock_thresh;
    logic               dp_rst;
    logic [3:0]         gardner_shift;
    logic               locked;
    logic [1:0]         state_o;
    logic [7:0]         loss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    gardner_loop_ctrl u_dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .sym_valid     (sym_valid),
        .error_n       (error_n),
        .lock_thresh   (lock_thresh),
        .unlock_thresh (unlock_thresh),
        .dp_rst        (dp_rst),
        .gardner_shift (gardner_shift),
        .locked        (locked),
        .state_o       (state_o),
        .loss_cnt      (loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int e, input int gap);
        sym_valid = 1'b1;
        error_n   = 16'(e);
        tick();
        sym_valid = 1'b0;
        error_n   = 16'sd0;
        repeat (gap - 1) tick();
    endtask

    // 32 strobes alternating -mag/+mag; closing strobe leaves us one cycle after it.
    task automatic window(input int mag);
        for (int i = 0; i < 32; i++) begin
            strobe((i % 2 == 1) ? mag : -mag, (i == 31) ? 1 : 3);
        end
    endtask

    task automatic acquire();
        repeat (255) strobe(0, 4);
        check_eq("acq_255_state", state_o, 2);
        check_eq("acq_255_shift", gardner_shift, 3);
        strobe(0, 1);
        check_eq("acq_256_shift", gardner_shift, 6);
        check_eq("acq_256_state", state_o, 3);
    endtask

    initial begin
        rst           = 1'b1;
        enable        = 1'b0;
        sym_valid     = 1'b0;
        error_n       = 16'sd0;
        lock_thresh   = 15'd100;
        unlock_thresh = 15'd400;
        repeat (3) tick();
        check_eq("rst_state",  state_o, 0);
        check_eq("rst_dp_rst", dp_rst, 1);
        check_eq("rst_shift",  gardner_shift, 3);
        check_eq("rst_locked", locked, 0);
        check_eq("rst_loss",   loss_cnt, 0);

        rst = 1'b0;
        tick();
        check_eq("idle_state", state_o, 0);

        // Start-up: four cycles of datapath reset
        enable = 1'b1;
        tick();
        check_eq("rd_state",  state_o, 1);
        check_eq("rd_dp_rst", dp_rst, 1);
        repeat (3) tick();
        check_eq("rd4_state",  state_o, 1);
        check_eq("rd4_dp_rst", dp_rst, 1);
        tick();
        check_eq("acq_dp_rst", dp_rst, 0);
        check_eq("acq_state",  state_o, 2);
        check_eq("acq_shift",  gardner_shift, 3);

        acquire();
        check_eq("trk_unlocked", locked, 0);

        // Lock window: |err|=50, sum 1600 < 3200; first half back-to-back
        for (int i = 0; i < 31; i++) begin
            strobe((i % 2 == 1) ? 50 : -50, (i < 16) ? 1 : 4);
        end
        check_eq("pre_lock", locked, 0);
        strobe(50, 1);
        check_eq("lock_set", locked, 1);

        // Hysteresis band, and neutral windows clearing the bad counter
        window(250);
        window(250);
        check_eq("hyst_locked", locked, 1);
        check_eq("hyst_state",  state_o, 3);
        window(500);
        window(500);
        window(250);
        check_eq("bad_clr_locked", locked, 1);

        // Loss: three consecutive bad windows
        window(500);
        window(500);
        check_eq("loss_pending", locked, 1);
        window(500);
        check_eq("loss_locked", locked, 0);
        check_eq("loss_state",  state_o, 2);
        check_eq("loss_shift",  gardner_shift, 3);
        check_eq("loss_cnt",    loss_cnt, c_exp_loss);

        acquire();

        // Saturating |x|: -32768 counts as 32767, sum equals the lock limit
        lock_thresh   = 15'd32767;
        unlock_thresh = 15'd32767;
        window(32768);
        check_eq("sat_no_lock", locked, 0);
        check_eq("sat_state",   state_o, 3);
        for (int i = 0; i < 31; i++) strobe(-32768, 2);
        strobe(-32766, 1);
        check_eq("sat_edge_lock", locked, 1);

        // Unlock compare is strict: sum == limit is not a bad window
        lock_thresh   = 15'd100;
        unlock_thresh = 15'd400;
        window(400);
        window(500);
        window(500);
        check_eq("unlock_edge_locked", locked, 1);
        check_eq("unlock_edge_state",  state_o, 3);

        // enable drop coincides with a loss-triggering window close
        for (int i = 0; i < 31; i++) strobe(500, 4);
        sym_valid = 1'b1;
        error_n   = 16'sd500;
        enable    = 1'b0;
        tick();
        sym_valid = 1'b0;
        check_eq("prio_state",  state_o, 0);
        check_eq("prio_dp_rst", dp_rst, 1);
        check_eq("prio_locked", locked, 0);
        check_eq("prio_shift",  gardner_shift, 3);
        check_eq("prio_loss",   loss_cnt, c_exp_loss);

        // Asynchronous reset in the middle of a tracking window
        enable = 1'b1;
        repeat (5) tick();
        check_eq("restart_state", state_o, 2);
        acquire();
        repeat (16) strobe(500, 2);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_state",  state_o, 0);
        check_eq("arst_dp_rst", dp_rst, 1);
        check_eq("arst_shift",  gardner_shift, 3);
        check_eq("arst_loss",   loss_cnt, 0);
        rst = 1'b0;
        tick();
        check_eq("post_rst_state", state_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
